pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : program counter sequencer with JMP/BRC/CALL/RET/HALT and a
//                one-cycle FLUSH bubble after every taken branch.
// Optional return stack: define PC_RETURN_STACK_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] i,
  input  logic [2:0] s,
  input  logic       val,
  input  logic [7:0] target,
  input  logic [7:0] flags,
  input  logic       instr_valid,
  input  logic       stall,
  output logic [7:0] pc,
  output logic       taken,
  output logic       flush,
  output logic       halted,
  output logic       stack_err
);

  localparam logic [4:0] c_OP_JMP  = 5'h10;
  localparam logic [4:0] c_OP_BRC  = 5'h11;
  localparam logic [4:0] c_OP_CALL = 5'h12;
  localparam logic [4:0] c_OP_RET  = 5'h13;
  localparam logic [4:0] c_OP_HALT = 5'h1F;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic       r_taken, w_taken_nxt;
  logic [7:0] w_seq;

  assign w_seq = r_pc + 8'd1;

`ifdef PC_RETURN_STACK_EN
  logic [7:0] r_stack [0:3];
  logic [2:0] r_sp;
  logic       r_err;
  logic       w_push, w_pop, w_err_set;
  logic [1:0] w_top;

  assign w_top = r_sp[1:0] - 2'd1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_taken_nxt = r_taken;
`ifdef PC_RETURN_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
`endif
    if (!stall) begin
      case (r_state)
        ST_RUN: begin
          w_taken_nxt = 1'b0;
          if (instr_valid) begin
            w_pc_nxt = w_seq;
            case (i)
              c_OP_JMP: begin
                w_pc_nxt    = target;
                w_taken_nxt = 1'b1;
                w_state_nxt = ST_FLUSH;
              end
              c_OP_BRC: begin
                // selector 7 is reserved as "never"
                if (s != 3'd7 && flags[s] == val) begin
                  w_pc_nxt    = target;
                  w_taken_nxt = 1'b1;
                  w_state_nxt = ST_FLUSH;
                end
              end
              c_OP_CALL: begin
                w_pc_nxt    = target;
                w_taken_nxt = 1'b1;
                w_state_nxt = ST_FLUSH;
`ifdef PC_RETURN_STACK_EN
                if (r_sp == 3'd4) w_err_set = 1'b1;
                else              w_push    = 1'b1;
`endif
              end
              c_OP_RET: begin
`ifdef PC_RETURN_STACK_EN
                if (r_sp == 3'd0) begin
                  w_err_set = 1'b1;
                end else begin
                  w_pop       = 1'b1;
                  w_pc_nxt    = r_stack[w_top];
                  w_taken_nxt = 1'b1;
                  w_state_nxt = ST_FLUSH;
                end
`endif
              end
              c_OP_HALT: begin
                w_pc_nxt    = r_pc;
                w_state_nxt = ST_HALT;
              end
              default: ;
            endcase
          end
        end
        ST_FLUSH: w_state_nxt = ST_RUN;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= 8'h00;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_taken <= w_taken_nxt;
    end
  end

`ifdef PC_RETURN_STACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp  <= 3'd0;
      r_err <= 1'b0;
    end else begin
      if (w_push)    r_sp  <= r_sp + 3'd1;
      if (w_pop)     r_sp  <= r_sp - 3'd1;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // entry contents deliberately carry no reset
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[1:0]] <= w_seq;
  end

  assign stack_err = r_err;
`else
  assign stack_err = 1'b0;
`endif

  assign pc     = r_pc;
  assign taken  = r_taken;
  assign flush  = (r_state == ST_FLUSH);
  assign halted = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed self-checking bench for pc_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] i;
  logic [2:0] s;
  logic       val;
  logic [7:0] target;
  logic [7:0] flags;
  logic       instr_valid;
  logic       stall;
  logic [7:0] pc;
  logic       taken, flush, halted, stack_err;

  int n_total = 0;
  int n_bad   = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .i(i), .s(s), .val(val), .target(target),
    .flags(flags), .instr_valid(instr_valid), .stall(stall),
    .pc(pc), .taken(taken), .flush(flush), .halted(halted),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] op, input logic [7:0] tgt);
    instr_valid = v;
    i           = op;
    target      = tgt;
  endtask

  // jump to an address and swallow the flush bubble
  task automatic go(input logic [7:0] tgt);
    drv(1'b1, 5'h10, tgt);
    tick();
    drv(1'b0, 5'h00, 8'h00);
    tick();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; s = 3'd0; val = 1'b0; flags = 8'h00;
    drv(1'b0, 5'h00, 8'h00);
    tick(); tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_taken", taken, 0);
    chk("rst_flush", flush, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", stack_err, 0);
    reset = 1'b0;

    // sequential ADDs
    drv(1'b1, 5'h00, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("add_pc", pc, k);
      chk("add_taken", taken, 0);
      chk("add_flush", flush, 0);
    end
    drv(1'b1, 5'h19, 8'h00);
    tick();
    chk("op19_pc", pc, 8'h04);

    // instr_valid low: pc holds, taken clears
    drv(1'b1, 5'h10, 8'h20);
    tick();
    chk("jmp_taken", taken, 1);
    drv(1'b1, 5'h10, 8'h99);
    tick();
    chk("flush_ignores_pc", pc, 8'h20);
    chk("flush_done", flush, 0);
    drv(1'b0, 5'h10, 8'h99);
    tick();
    chk("idle_pc", pc, 8'h20);
    chk("idle_taken", taken, 0);

    // BRC taken on Z
    flags = 8'h01; s = 3'd0; val = 1'b1;
    drv(1'b1, 5'h11, 8'h80);
    tick();
    chk("brc_t_pc", pc, 8'h80);
    chk("brc_t_taken", taken, 1);
    chk("brc_t_flush", flush, 1);
    drv(1'b1, 5'h00, 8'h00);
    tick();
    chk("brc_t_bubble_pc", pc, 8'h80);
    chk("brc_t_flush_end", flush, 0);

    // BRC not taken
    go(8'h20);
    flags = 8'h00;
    drv(1'b1, 5'h11, 8'h80);
    tick();
    chk("brc_n_pc", pc, 8'h21);
    chk("brc_n_taken", taken, 0);
    chk("brc_n_flush", flush, 0);

    // selector 7 never taken, even when flags[7] matches
    flags = 8'hFF; s = 3'd7; val = 1'b1;
    tick();
    chk("brc_s7_pc", pc, 8'h22);
    chk("brc_s7_taken", taken, 0);

    // BRC taken on carry clear (val=0)
    flags = 8'h00; s = 3'd3; val = 1'b0;
    tick();
    chk("brc_v0_pc", pc, 8'h80);
    chk("brc_v0_taken", taken, 1);
    drv(1'b0, 5'h00, 8'h00);
    tick();

    // wraparound then stall
    go(8'hFF);
    drv(1'b1, 5'h05, 8'h00);
    tick();
    chk("wrap_pc", pc, 8'h00);
    stall = 1'b1;
    drv(1'b1, 5'h10, 8'h55);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", pc, 8'h00);
      chk("stall_flush", flush, 0);
    end
    stall = 1'b0;

    // stall stretches FLUSH
    tick();
    chk("jmp55_pc", pc, 8'h55);
    stall = 1'b1;
    tick(); tick();
    chk("stall_flush_hold", flush, 1);
    chk("stall_taken_hold", taken, 1);
    stall = 1'b0;
    drv(1'b0, 5'h00, 8'h00);
    tick();
    chk("flush_release", flush, 0);

`ifdef PC_RETURN_STACK_EN
    for (int k = 0; k < 5; k++) begin
      go(8'h10);
      drv(1'b1, 5'h12, 8'h40);
      tick();
      chk("call_pc", pc, 8'h40);
      chk("call_taken", taken, 1);
      chk("call_err", stack_err, (k == 4) ? 1 : 0);
      drv(1'b0, 5'h00, 8'h00);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 5'h13, 8'h00);
      tick();
      chk("ret_pc", pc, 8'h11);
      chk("ret_taken", taken, 1);
      chk("ret_flush", flush, 1);
      drv(1'b0, 5'h00, 8'h00);
      tick();
    end
    drv(1'b1, 5'h13, 8'h00);
    tick();
    chk("ret_empty_pc", pc, 8'h12);
    chk("ret_empty_taken", taken, 0);
    chk("ret_empty_err", stack_err, 1);
`else
    go(8'h10);
    drv(1'b1, 5'h12, 8'h40);
    tick();
    chk("call_pc", pc, 8'h40);
    chk("call_taken", taken, 1);
    chk("call_flush", flush, 1);
    drv(1'b0, 5'h00, 8'h00);
    tick();
    drv(1'b1, 5'h13, 8'hAA);
    tick();
    chk("ret_pc", pc, 8'h41);
    chk("ret_taken", taken, 0);
    chk("ret_flush", flush, 0);
    chk("ret_err", stack_err, 0);
`endif

    // HALT, then async reset
    go(8'h05);
    drv(1'b1, 5'h1F, 8'h00);
    tick();
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 8'h05);
    drv(1'b1, 5'h10, 8'h77);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("halt_hold_pc", pc, 8'h05);
      chk("halt_hold_flag", halted, 1);
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", pc, 8'h00);
    chk("async_rst_halted", halted, 0);
    tick();
    reset = 1'b0;
    drv(1'b1, 5'h00, 8'h00);
    tick();
    chk("post_rst_accept", pc, 8'h01);

    // reset in the middle of FLUSH
    drv(1'b1, 5'h10, 8'h30);
    tick();
    chk("pre_rst_flush", flush, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_flush", flush, 0);
    chk("rst_mid_flush_pc", pc, 8'h00);
    chk("rst_mid_flush_err", stack_err, 0);
    tick();
    reset = 1'b0;
    drv(1'b1, 5'h10, 8'h3C);
    tick();
    chk("post_flush_rst_accept", pc, 8'h3C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
